// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end.
// Holds the scanner state encoding, the default debounce length and
// the names of the sixteen key codes produced by the scanner. Codes
// are row*4+col on the physical keypad:
//   row 0 :  1   2   3   +
//   row 1 :  4   5   6   -
//   row 2 :  7   8   9   *
//   row 3 :  C   0   =   /
package calc_pkg;

    localparam int DEFAULT_DEBOUNCE_TICKS = 20;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        REPORT,
        HOLD
    } scan_state_e;

    localparam logic [3:0] KEY_1     = 4'd0;
    localparam logic [3:0] KEY_2     = 4'd1;
    localparam logic [3:0] KEY_3     = 4'd2;
    localparam logic [3:0] KEY_ADD   = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_SUB   = 4'd7;
    localparam logic [3:0] KEY_7     = 4'd8;
    localparam logic [3:0] KEY_8     = 4'd9;
    localparam logic [3:0] KEY_9     = 4'd10;
    localparam logic [3:0] KEY_MUL   = 4'd11;
    localparam logic [3:0] KEY_CLEAR = 4'd12;
    localparam logic [3:0] KEY_0     = 4'd13;
    localparam logic [3:0] KEY_ENTER = 4'd14;
    localparam logic [3:0] KEY_DIV   = 4'd15;

    // Active-low row drive: exactly one row pulled low.
    function automatic logic [3:0] rowDrive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Index of the lowest-numbered low column (caller checks that one is low).
    function automatic logic [1:0] lowestLow(input logic [3:0] cols);
        if (!cols[0])      return 2'd0;
        else if (!cols[1]) return 2'd1;
        else if (!cols[2]) return 2'd2;
        else               return 2'd3;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk      system clock
//   reset    synchronous, active-low reset
//   async_i  level from another clock domain, treated as data
//   tick_o   one-clk pulse per synchronized rising edge
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic tick_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] fill_q;

    // fill_q counts the edges since reset until prev_q holds a genuine
    // sample; until then an input that was already high would look like
    // a fresh rising edge, so the detector stays disarmed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 2'd0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    assign tick_o = (fill_q == 2'd3) && sync_q && !prev_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounced press and release.
// Walks the active-low row drive one row per scan tick, locks onto the
// first low column found, debounces it, reports it once and then waits
// for a debounced release before resuming the scan.
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   scan_clk   slow divided clock, sampled as data to make scan ticks
//   col_in     keypad columns, active-low
//   row_out    keypad rows, active-low, one row low at a time
//   key_code   last accepted key, row*4+col
//   key_valid  one-clk pulse when a key is accepted
//   key_down   high from acceptance until the release is debounced
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_clk,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    scan_state_e      state_q;
    logic [1:0]       rowIdx_q;
    logic [1:0]       capCol_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       keyCode_q;
    logic             keyValid_q;
    logic             keyDown_q;
    logic [3:0]       colMeta_q;
    logic [3:0]       colSync_q;

    logic tick;
    logic anyLow;
    logic capLow;

    sync_edge u_scanTick (
        .clk     (clk),
        .reset   (reset),
        .async_i (scan_clk),
        .tick_o  (tick)
    );

    assign anyLow = (colSync_q != 4'hF);
    assign capLow = !colSync_q[capCol_q];

    // Column synchronizer plus the scan/debounce state machine. The row
    // index doubles as the captured row while a key is being tracked, so
    // the row drive stays put through DEBOUNCE, REPORT and HOLD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= SCAN;
            rowIdx_q   <= 2'd0;
            capCol_q   <= 2'd0;
            cnt_q      <= '0;
            keyCode_q  <= 4'd0;
            keyValid_q <= 1'b0;
            keyDown_q  <= 1'b0;
            colMeta_q  <= 4'hF;
            colSync_q  <= 4'hF;
        end else begin
            colMeta_q  <= col_in;
            colSync_q  <= colMeta_q;
            keyValid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (tick) begin
                        if (anyLow) begin
                            capCol_q <= lowestLow(colSync_q);
                            cnt_q    <= '0;
                            state_q  <= DEBOUNCE;
                        end else begin
                            rowIdx_q <= rowIdx_q + 2'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tick) begin
                        if (!capLow) begin
                            state_q  <= SCAN;
                            rowIdx_q <= rowIdx_q + 2'd1;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q    <= REPORT;
                            keyValid_q <= 1'b1;
                            keyCode_q  <= {rowIdx_q, capCol_q};
                            keyDown_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                REPORT: begin
                    state_q <= HOLD;
                    cnt_q   <= '0;
                end
                HOLD: begin
                    if (tick) begin
                        if (capLow) begin
                            cnt_q <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            keyDown_q <= 1'b0;
                            state_q   <= SCAN;
                            rowIdx_q  <= rowIdx_q + 2'd1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    // The valid pulse is masked by reset so that a reset arriving during
    // the REPORT cycle suppresses the pulse rather than letting it escape.
    assign row_out   = rowDrive(rowIdx_q);
    assign key_code  = keyCode_q;
    assign key_valid = keyValid_q & reset;
    assign key_down  = keyDown_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with DEBOUNCE_TICKS = 4.
// A small keypad model turns the set of pressed keys plus the row drive
// into the column levels. Each scan tick is one full scan_clk period.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic        scanClk;
    logic [3:0]  colIn;
    logic [3:0]  rowOut;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyDown;

    logic [15:0] pressed;
    logic [3:0]  validCount = 4'd0;
    logic        validAtTick;
    logic        downAtTick;
    logic [3:0]  codeAtTick;
    logic [3:0]  rowSeq [8];
    int          checks = 0;
    int          errors = 0;

    keypad_scanner #(
        .DEBOUNCE_TICKS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_clk  (scanClk),
        .col_in    (colIn),
        .row_out   (rowOut),
        .key_code  (keyCode),
        .key_valid (keyValid),
        .key_down  (keyDown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its column to its row.
    always_comb begin
        colIn = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !rowOut[r]) begin
                    colIn[c] = 1'b0;
                end
            end
        end
    end

    // Counts every key_valid pulse seen mid-cycle.
    always @(negedge clk) begin
        if (keyValid === 1'b1) begin
            validCount <= validCount + 4'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One scan_clk period; outputs are captured in the cycle right after
    // the DUT consumes the tick.
    task automatic applyStimulus();
        scanClk = 1'b1;
        repeat (3) @(negedge clk);
        validAtTick = keyValid;
        downAtTick  = keyDown;
        codeAtTick  = keyCode;
        scanClk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rowSeq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
        reset   = 1'b0;
        scanClk = 1'b0;
        pressed = 16'h0000;
        repeat (3) @(negedge clk);

        checkOutput("rstRow",   rowOut,            4'hE);
        checkOutput("rstCode",  keyCode,           4'h0);
        checkOutput("rstValid", {3'b000, keyValid}, 4'h0);
        checkOutput("rstDown",  {3'b000, keyDown},  4'h0);

        // scan_clk already high when reset is released
        scanClk = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("noFalseTick", rowOut, 4'hE);
        scanClk = 1'b0;
        repeat (3) @(negedge clk);

        // idle scanning
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("idleRow%0d", i), rowOut, rowSeq[i]);
            applyStimulus();
            checkOutput($sformatf("idleStable%0d", i), rowOut, rowSeq[(i + 1) % 8 == 0 ? 0 : (i + 1)]);
        end
        checkOutput("idleWrap", rowOut, 4'hE);

        // clean press of row 2 / col 1
        pressed[9] = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("detectRowHeld", rowOut, 4'hB);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus();
            checkOutput($sformatf("pressValidTick%0d", k), {3'b000, validAtTick}, (k == 4) ? 4'h1 : 4'h0);
        end
        checkOutput("pressCode",       codeAtTick,         4'h9);
        checkOutput("pressDown",       {3'b000, downAtTick}, 4'h1);
        checkOutput("pressValidAfter", {3'b000, keyValid},  4'h0);
        checkOutput("pressCount",      validCount,         4'h1);

        // bouncing release
        pressed[9] = 1'b0;
        applyStimulus();
        checkOutput("bounceHigh", {3'b000, keyDown}, 4'h1);
        pressed[9] = 1'b1;
        applyStimulus();
        checkOutput("bounceLow", {3'b000, keyDown}, 4'h1);
        pressed[9] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus();
            checkOutput($sformatf("releaseTick%0d", k), {3'b000, keyDown}, (k == 4) ? 4'h0 : 4'h1);
        end
        checkOutput("releaseRow",   rowOut,     4'h7);
        checkOutput("releaseCount", validCount, 4'h1);

        // short glitch on row 3 / col 0
        pressed[12] = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("glitchRowHeld", rowOut, 4'h7);
        pressed[12] = 1'b0;
        applyStimulus();
        checkOutput("glitchRowNext", rowOut,            4'hE);
        checkOutput("glitchCount",   validCount,        4'h1);
        checkOutput("glitchDown",    {3'b000, keyDown}, 4'h0);
        checkOutput("glitchCode",    keyCode,           4'h9);

        // row 1: col 3 and col 0 together, then a row 3 press during HOLD
        pressed[7] = 1'b1;
        pressed[4] = 1'b1;
        applyStimulus();
        applyStimulus();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus();
        end
        checkOutput("dualValid", {3'b000, validAtTick}, 4'h1);
        checkOutput("dualCode",  codeAtTick,            4'h4);
        pressed[13] = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("holdRow",   rowOut,            4'hD);
        checkOutput("holdDown",  {3'b000, keyDown}, 4'h1);
        checkOutput("holdCode",  keyCode,           4'h4);
        checkOutput("holdCount", validCount,        4'h2);
        pressed = 16'h0000;
        repeat (4) applyStimulus();
        checkOutput("dualRelease", {3'b000, keyDown}, 4'h0);
        checkOutput("dualNextRow", rowOut,            4'hB);

        // reset during DEBOUNCE
        pressed[9] = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstDbRow",   rowOut,             4'hE);
        checkOutput("rstDbCode",  keyCode,            4'h0);
        checkOutput("rstDbDown",  {3'b000, keyDown},  4'h0);
        checkOutput("rstDbValid", {3'b000, keyValid}, 4'h0);
        reset = 1'b1;
        pressed = 16'h0000;
        pressed[2] = 1'b1;
        repeat (4) @(negedge clk);

        // reset during REPORT
        applyStimulus();
        repeat (3) applyStimulus();
        scanClk = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("rptReached", {3'b000, keyDown},  4'h1);
        checkOutput("rptValid",   {3'b000, keyValid}, 4'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstRptRow",   rowOut,            4'hE);
        checkOutput("rstRptCode",  keyCode,           4'h0);
        checkOutput("rstRptDown",  {3'b000, keyDown}, 4'h0);
        checkOutput("rstRptCount", validCount,        4'h2);

        scanClk = 1'b0;
        pressed = 16'h0000;
        reset   = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 20, meaning consecutive scan ticks of stable level required to accept a press or a release (legal range 1..255).
REQ-002 SHALL have ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-low reset.
- scan_clk  input  1  divided clock from the clock divider; treated as data, never used as a clock.
- col_in  input  4  keypad columns; active-low, externally pulled up.
- row_out  output  4  keypad rows; active-low, exactly one row low at all times.
- key_code  output  4  last accepted key, row*4+col.
- key_valid  output  1  one-clk pulse when a key is accepted.
- key_down  output  1  level; high from acceptance until release is debounced.

Function
REQ-003 SHALL pass scan_clk through a 2-flop synchronizer and generate tick, a one-clk pulse on each synchronized rising edge; all scan and debounce state advances only on tick.
REQ-004 SHALL pass col_in through a 2-flop synchronizer; all column decisions use the synchronized value sampled on tick.
REQ-005 SHALL implement the states SCAN, DEBOUNCE, REPORT and HOLD.
REQ-006 SCAN: row_out = ~(1<<row_idx); on a tick with all columns high, row_idx increments and wraps 3->0.
REQ-007 SCAN: on a tick with any column low:
- capture row_idx and the lowest-index low column;
- clear cnt;
- enter DEBOUNCE with row_out held.
REQ-008 DEBOUNCE: on each tick with the captured column still low, cnt increments.
REQ-009 DEBOUNCE: on the tick where cnt equals DEBOUNCE_TICKS-1 with the column still low, SHALL enter REPORT.
REQ-010 DEBOUNCE: on a tick with the captured column high, SHALL return to SCAN with row_idx+1 (wrap), and SHALL NOT pulse key_valid.
REQ-011 REPORT: SHALL last exactly one clk cycle, regardless of tick.
REQ-012 REPORT: key_valid=1, key_code={row,col}, key_down goes 1; then enter HOLD with cnt cleared.
REQ-013 HOLD: row held; on each tick with the captured column high, cnt increments; a tick with it low clears cnt.
REQ-014 HOLD: when cnt reaches DEBOUNCE_TICKS-1 on a high tick, SHALL:
- clear key_down;
- return to SCAN with row_idx+1;
- not pulse key_valid.
REQ-015 Other columns or rows pressed during DEBOUNCE or HOLD SHALL be ignored; with simultaneous presses, the first row in scan order and then the lowest column wins.
REQ-016 key_code SHALL retain its value until the next REPORT.
REQ-017 cnt width SHALL be clog2(DEBOUNCE_TICKS+1) bits; cnt SHALL never wrap.
REQ-018 Latency: key_valid SHALL rise in the clk cycle after the DEBOUNCE_TICKS-th tick following the detection tick.

Reset
REQ-019 When reset=0 at a clk edge, SHALL load:
- state SCAN, row_idx 0, row_out 4'b1110;
- key_code 0, key_valid 0, key_down 0, cnt 0;
- col synchronizer flops 1, scan_clk synchronizer and edge flops 0.
REQ-020 Reset SHALL win over a simultaneous tick or REPORT.
REQ-021 Reset mid-DEBOUNCE, mid-REPORT or mid-HOLD SHALL abort with no key_valid pulse and key_down 0.
REQ-022 After reset is released, the first tick SHALL NOT be falsely generated if scan_clk is already high.

Structure
REQ-023 Shared package calc_pkg SHALL hold:
- the scanner state enumeration;
- the 4-bit key code constants (digits, operators, ENTER, CLEAR) mapping row*4+col to calculator functions;
- the default DEBOUNCE_TICKS.
REQ-024 SHALL instantiate one sub-module sync_edge (2-flop synchronizer plus rising-edge detector, output tick) for scan_clk; col_in synchronization stays inline.

Verification
REQ-025 DEBOUNCE_TICKS=4; hold row 2/col 1 low → exactly one key_valid pulse, key_code=9, key_down=1 the clk cycle after the 4th tick following detection.
REQ-026 DEBOUNCE_TICKS=4; col pulled low for 2 ticks then released → no key_valid, key_down stays 0, scanning resumes at the next row.
REQ-027 Release bouncing (high, low, high ×4 ticks) → key_down falls only after 4 consecutive high ticks; no second key_valid.
REQ-028 Simultaneous press of row1/col3 and row1/col0 → key_code=4; later press of row3 during HOLD is ignored.
REQ-029 Reset asserted during DEBOUNCE, and again in the REPORT cycle → no key_valid; row_out=4'b1110, key_code=0, key_down=0 on the next cycle.
REQ-030 With no key pressed, 8 ticks → row_out sequence E,D,B,7,E,D,B,7; row_out constant between ticks.
